mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline CPU.
- Sits directly downstream of the EX/M pipeline register and consumes its outputs: ALU result, store data, destination register and control bits.
- Performs loads and stores over a ready-handshaked data-memory port, resolves branches, and contains the M/WB pipeline register that feeds write-back.
- Stalls upstream while a memory access is outstanding.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-file address width.
- TIMEOUT, 255, maximum WAIT cycles before abort. Used only with DMEM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Resetn  in  1  synchronous reset, active-high.
- valid_i  in  1  EX/M slot holds a real instruction.
- ALUout_i  in  32  ALU result; memory byte address for loads/stores.
- busB_i  in  32  store data.
- Rd_i  in  5  destination register.
- zero_i  in  1  ALU zero flag.
- branch_target_i  in  32  branch target PC.
- MemtoReg_i  in  1  write-back source: 1 = memory, 0 = ALU.
- Regwr_i  in  1  register write enable.
- MemWr_i  in  1  store.
- MemRd_i  in  1  load.
- Branch_i  in  1  conditional branch.
- MemSize_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- MemSigned_i  in  1  sign-extend loads.
- stall_o  out  1  upstream must hold its current instruction.
- PCSrc_o  out  1  take branch.
- branch_pc_o  out  32  branch target.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- bus_err_o  out  1  one-cycle pulse on a timeout abort.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word address; bits [1:0] always 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  request completes this cycle.
- dmem_rdata  in  32  read data; valid when dmem_ready = 1.
- wb_valid  out  1  M/WB slot valid.
- wb_Regwr  out  1  registered write enable.
- wb_MemtoReg  out  1  registered write-back select.
- wb_Rd  out  5  registered destination register.
- wb_ALUout  out  32  registered ALU result.
- wb_MemData  out  32  registered, extended load data.

Behaviour:
- Reset: at a rising edge with Resetn = 1, state goes to IDLE and every registered output goes to 0, including dmem_req and all wb_* outputs. Reset during WAIT abandons the access; dmem_ready is ignored in IDLE.
- States: IDLE and WAIT. stall_o = (state == WAIT).
- Accept: an instruction is accepted when state = IDLE and valid_i = 1. An accepted instruction is consumed and upstream advances. There is no accept in WAIT.
- Memory op: memop = MemWr_i | MemRd_i.
- Non-memop accept: the M/WB register loads the instruction. wb_valid = 1 one cycle later, carrying ALUout_i, Rd_i, Regwr_i and MemtoReg_i.
- Memop accept with aligned address: the request is registered and state goes to WAIT.
  - dmem_req = 1 from the next cycle and holds with stable addr, be, wdata and we until the cycle dmem_ready = 1.
  - That request cycle then ends; at the next edge state = IDLE and dmem_req = 0.
  - For a load, the extracted data goes to wb_MemData and wb_valid = 1 at the edge leaving WAIT.
  - For a store, wb_valid = 1 with wb_Regwr = 0.
- Bubbles: the M/WB register loads a bubble (wb_valid = 0, wb_Regwr = 0) in every other cycle, i.e. the memop accept cycle and WAIT cycles without dmem_ready.
- Alignment:
  - Half is misaligned if addr[0] = 1.
  - Word is misaligned if addr[1:0] != 0.
  - A misaligned access issues no request and stays in IDLE. misalign_o = 1 for one cycle after accept. A bubble goes to WB.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Extension is sign or zero per MemSigned_i.
  - Word load passes data unchanged.
- Store:
  - Byte: wdata = {4{b}}, be = 0001 << addr[1:0].
  - Half: wdata = {2{h}}, be = 0011 or 1100.
  - Word: be = 1111.
- Branch: PCSrc_o = valid_i & Branch_i & zero_i & (state == IDLE). This is combinational. branch_pc_o = branch_target_i.
- Simultaneous memop and Branch: the branch resolves in the accept cycle and the memop proceeds normally.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entering WAIT and increments each WAIT cycle without dmem_ready.
  - When the count reaches TIMEOUT, the block drops dmem_req and returns to IDLE.
  - bus_err_o pulses for 1 cycle and a bubble goes to WB.
  - dmem_ready in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; bus_err_o is tied to 0 and WAIT lasts until dmem_ready.

Test Plan:
- Non-memop: ALUout_i = 0x1234, Rd_i = 7, Regwr_i = 1 -> next cycle wb_valid = 1, wb_ALUout = 0x1234, wb_Rd = 7, stall_o = 0 throughout.
- LB signed: addr = 0x103, rdata = 0x80FF_FF7F, ready 2 cycles after req -> dmem_addr = 0x100, stall_o high 2 cycles, wb_MemData = 0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH: addr = 0x202, busB = 0xAAAA_BEEF -> dmem_be = 1100, dmem_wdata = 0xBEEF_BEEF, dmem_we = 1, wb_Regwr = 0.
- Misaligned LW: addr = 0x301 -> no dmem_req, misalign_o = 1 for one cycle, wb_valid = 0.
- Reset in WAIT: Resetn = 1 at WAIT cycle 1 -> next cycle dmem_req = 0, stall_o = 0, wb_valid = 0. A late dmem_ready is ignored.
- With DMEM_TIMEOUT_EN and TIMEOUT = 4, ready never asserted -> dmem_req drops after 4 WAIT cycles and bus_err_o pulses once.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory-access stage. It issues loads and stores over
//               a ready-handshaked data port, resolves branches and holds the
//               M/WB register. The optional macro DMEM_TIMEOUT_EN aborts
//               accesses that wait too long.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              Resetn,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] ALUout_i,
    input  logic [DATA_W-1:0] busB_i,
    input  logic [REG_AW-1:0] Rd_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] branch_target_i,
    input  logic              MemtoReg_i,
    input  logic              Regwr_i,
    input  logic              MemWr_i,
    input  logic              MemRd_i,
    input  logic              Branch_i,
    input  logic [1:0]        MemSize_i,
    input  logic              MemSigned_i,
    output logic              stall_o,
    output logic              PCSrc_o,
    output logic [DATA_W-1:0] branch_pc_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_Regwr,
    output logic              wb_MemtoReg,
    output logic [REG_AW-1:0] wb_Rd,
    output logic [DATA_W-1:0] wb_ALUout,
    output logic [DATA_W-1:0] wb_MemData
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_accept;
    logic                w_memop;
    logic                w_misalign;
    logic                w_issue;
    logic                w_done;
    logic                w_timeout;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load_data;

    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_is_load;
    logic [REG_AW-1:0]   r_rd;
    logic                r_regwr;
    logic                r_memtoreg;
    logic [DATA_W-1:0]   r_aluout;

    assign w_accept    = (r_state == S_IDLE) && valid_i;
    assign w_memop     = MemWr_i | MemRd_i;
    assign w_issue     = w_accept && w_memop && !w_misalign;
    assign w_done      = (r_state == S_WAIT) && dmem_ready;

    assign stall_o     = (r_state == S_WAIT);
    assign PCSrc_o     = valid_i & Branch_i & zero_i & (r_state == S_IDLE);
    assign branch_pc_o = branch_target_i;

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = busB_i;
        case (MemSize_i)
            2'b00: begin
                w_be    = 4'b0001 << ALUout_i[1:0];
                w_wdata = {4{busB_i[7:0]}};
            end
            2'b01: begin
                w_misalign = ALUout_i[0];
                w_be       = ALUout_i[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{busB_i[15:0]}};
            end
            default: begin
                w_misalign = |ALUout_i[1:0];
            end
        endcase
    end

    // Lane selection uses the address captured at issue, not the live input.
    always_comb begin
        w_load_data = dmem_rdata;
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{(DATA_W-8){r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{(DATA_W-16){r_signed & w_half[15]}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Resetn) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int c_TCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [c_TCNT_W-1:0] r_tcnt;

    // Ready in the final cycle still completes normally.
    assign w_timeout = (r_state == S_WAIT) && !dmem_ready &&
                       (r_tcnt == c_TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (Resetn)                                  r_tcnt <= '0;
        else if (w_issue)                            r_tcnt <= '0;
        else if ((r_state == S_WAIT) && !dmem_ready) r_tcnt <= r_tcnt + c_TCNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (Resetn) bus_err_o <= 1'b0;
        else        bus_err_o <= w_timeout;
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |TIMEOUT;
    assign w_timeout        = 1'b0;
    assign bus_err_o        = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Resetn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            r_lane     <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_is_load  <= 1'b0;
            r_rd       <= '0;
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluout   <= '0;
        end else if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWr_i;
            dmem_addr  <= {ALUout_i[DATA_W-1:2], 2'b00};
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata;
            r_lane     <= ALUout_i[1:0];
            r_size     <= MemSize_i;
            r_signed   <= MemSigned_i;
            r_is_load  <= !MemWr_i;
            r_rd       <= Rd_i;
            r_regwr    <= Regwr_i;
            r_memtoreg <= MemtoReg_i;
            r_aluout   <= ALUout_i;
        end else if (w_done || w_timeout) begin
            dmem_req   <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Resetn) misalign_o <= 1'b0;
        else        misalign_o <= w_accept && w_memop && w_misalign;
    end

    // Every cycle that neither retires nor completes an access loads a bubble.
    always_ff @(posedge CLK) begin
        if (Resetn) begin
            wb_valid    <= 1'b0;
            wb_Regwr    <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_Rd       <= '0;
            wb_ALUout   <= '0;
            wb_MemData  <= '0;
        end else if (w_accept && !w_memop) begin
            wb_valid    <= 1'b1;
            wb_Regwr    <= Regwr_i;
            wb_MemtoReg <= MemtoReg_i;
            wb_Rd       <= Rd_i;
            wb_ALUout   <= ALUout_i;
            wb_MemData  <= '0;
        end else if (w_done) begin
            wb_valid    <= 1'b1;
            wb_Regwr    <= r_regwr & r_is_load;
            wb_MemtoReg <= r_memtoreg;
            wb_Rd       <= r_rd;
            wb_ALUout   <= r_aluout;
            wb_MemData  <= r_is_load ? w_load_data : '0;
        end else begin
            wb_valid    <= 1'b0;
            wb_Regwr    <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_Rd       <= '0;
            wb_ALUout   <= '0;
            wb_MemData  <= '0;
        end
    end

endmodule

`default_nettype wire
